button_conditioner: RTL and testbench

Front-end stage that turns the raw push-button inputs BTNC and BTND into clean, synchronized, debounced signals for the ALU calculator control FSM. Per button it provides a one-cycle press pulse, which is the FSM's step/back input, and a debounced level. It sits between the board pins and the ALU control state machine and runs on the board clock.

---
 rtl/alu_pkg.sv | 15 +
 rtl/debounce_channel.sv | 96 +++++++++
 rtl/button_conditioner.sv | 39 +++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU calculator front end.
package alu_pkg;

    // Per-button debounce FSM states; the level output is 1 in PRESSED and RELEASE_CHECK.
    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_CHECK,
        DB_PRESSED,
        DB_RELEASE_CHECK
    } db_state_t;

    // 10 ms at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchronizer, stability counter,
// 4-state debounce FSM, and registered press pulse / debounced level.
module debounce_channel
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o,
    output logic level_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             level_q;

    // Bring the asynchronous button into the clock domain; only sync2_q is used below.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM: the counter clears on every state change and counts confirming
    // samples in a CHECK state; pulse fires only on PRESS_CHECK -> PRESSED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                DB_IDLE: begin
                    if (sync2_q) begin
                        state_q <= DB_PRESS_CHECK;
                        cnt_q   <= '0;
                    end
                end
                DB_PRESS_CHECK: begin
                    if (!sync2_q) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_PRESSED;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DB_PRESSED: begin
                    if (!sync2_q) begin
                        state_q <= DB_RELEASE_CHECK;
                        cnt_q   <= '0;
                    end
                end
                DB_RELEASE_CHECK: begin
                    if (sync2_q) begin
                        state_q <= DB_PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= DB_IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions BTNC and BTND into step/back pulses and debounced levels for the
// ALU control FSM. The two channels are fully independent; simultaneous presses
// may pulse in the same cycle and are left for the consumer to arbitrate.
module button_conditioner
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic BTNC,
    input  logic BTND,
    output logic btnc_pulse,
    output logic btnd_pulse,
    output logic btnc_level,
    output logic btnd_level
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_c (
        .clk_i  (CLK100MHZ),
        .rst_ni (CPU_RESETN),
        .btn_i  (BTNC),
        .pulse_o(btnc_pulse),
        .level_o(btnc_level)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_d (
        .clk_i  (CLK100MHZ),
        .rst_ni (CPU_RESETN),
        .btn_i  (BTND),
        .pulse_o(btnd_pulse),
        .level_o(btnd_level)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a short debounce window.
module tb_button_conditioner;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic btnc;
    logic btnd;
    logic btnc_pulse;
    logic btnd_pulse;
    logic btnc_level;
    logic btnd_level;

    int total = 0;
    int bad   = 0;

    // Expected {btnc_pulse, btnc_level, btnd_pulse, btnd_level} per clock edge.
    logic [3:0] exp_q[$];

    // Reference: raw samples delayed two edges, tracked as run lengths.
    logic m_s1[2];
    logic m_s2[2];
    logic m_prev[2];
    int   m_run[2];
    logic m_lvl[2];

    typedef struct {
        logic c;
        logic d;
        int   cycles;
        int   pc;
        int   pd;
        logic lc;
        logic ld;
    } seg_t;

    seg_t segs[15];

    button_conditioner #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .BTNC      (btnc),
        .BTND      (btnd),
        .btnc_pulse(btnc_pulse),
        .btnd_pulse(btnd_pulse),
        .btnc_level(btnc_level),
        .btnd_level(btnd_level)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i]   = 1'b0;
            m_s2[i]   = 1'b0;
            m_prev[i] = 1'b0;
            m_run[i]  = 0;
            m_lvl[i]  = 1'b0;
        end
        exp_q.delete();
    endtask

    // Predict the outputs after the next rising edge given the raw inputs it samples.
    task automatic model_edge(input logic c_in, input logic d_in, output logic [3:0] e);
        logic x[2];
        logic p[2];
        logic v;
        x[0] = c_in;
        x[1] = d_in;
        for (int i = 0; i < 2; i++) begin
            v = m_s2[i];
            if (v == m_prev[i]) m_run[i]++;
            else m_run[i] = 1;
            m_prev[i] = v;
            p[i] = 1'b0;
            if (!m_lvl[i] && v && m_run[i] >= N + 1) begin
                p[i] = 1'b1;
                m_lvl[i] = 1'b1;
            end else if (m_lvl[i] && !v && m_run[i] >= N + 1) begin
                m_lvl[i] = 1'b0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = x[i];
        end
        e = {p[0], m_lvl[0], p[1], m_lvl[1]};
    endtask

    // Drive one cycle of inputs, score the outputs just after the sampling edge.
    task automatic cycle(input logic c, input logic d);
        logic [3:0] e;
        @(negedge clk);
        btnc = c;
        btnd = d;
        model_edge(c, d, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk("per_cycle", {28'd0, btnc_pulse, btnc_level, btnd_pulse, btnd_level}, {28'd0, exp_q.pop_front()});
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release just after an edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", {28'd0, btnc_pulse, btnc_level, btnd_pulse, btnd_level}, 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int pc;
        int pd;
        rst_n = 1'b0;
        btnc  = 1'b0;
        btnd  = 1'b0;
        do_reset();

        // Segment table: inputs held for a number of cycles, expected pulse counts and end levels.
        segs[0]  = '{1'b0, 1'b0, 5,   0, 0, 1'b0, 1'b0};
        segs[1]  = '{1'b1, 1'b0, 10,  1, 0, 1'b1, 1'b0};
        segs[2]  = '{1'b0, 1'b0, 10,  0, 0, 1'b0, 1'b0};
        segs[3]  = '{1'b1, 1'b0, 1,   0, 0, 1'b0, 1'b0};
        segs[4]  = '{1'b0, 1'b0, 1,   0, 0, 1'b0, 1'b0};
        segs[5]  = '{1'b1, 1'b0, 1,   0, 0, 1'b0, 1'b0};
        segs[6]  = '{1'b0, 1'b0, 1,   0, 0, 1'b0, 1'b0};
        segs[7]  = '{1'b1, 1'b0, 10,  1, 0, 1'b1, 1'b0};
        segs[8]  = '{1'b0, 1'b0, 2,   0, 0, 1'b1, 1'b0};
        segs[9]  = '{1'b1, 1'b0, 8,   0, 0, 1'b1, 1'b0};
        segs[10] = '{1'b0, 1'b0, 10,  0, 0, 1'b0, 1'b0};
        segs[11] = '{1'b0, 1'b1, 100, 0, 1, 1'b0, 1'b1};
        segs[12] = '{1'b0, 1'b0, 10,  0, 0, 1'b0, 1'b0};
        segs[13] = '{1'b1, 1'b1, 10,  1, 1, 1'b1, 1'b1};
        segs[14] = '{1'b0, 1'b0, 10,  0, 0, 1'b0, 1'b0};

        for (int s = 0; s < 15; s++) begin
            pc = 0;
            pd = 0;
            for (int k = 0; k < segs[s].cycles; k++) begin
                cycle(segs[s].c, segs[s].d);
                pc += int'(btnc_pulse);
                pd += int'(btnd_pulse);
            end
            chk($sformatf("seg%0d_c_pulses", s), pc, segs[s].pc);
            chk($sformatf("seg%0d_d_pulses", s), pd, segs[s].pd);
            chk($sformatf("seg%0d_c_level", s), {31'd0, btnc_level}, {31'd0, segs[s].lc});
            chk($sformatf("seg%0d_d_level", s), {31'd0, btnd_level}, {31'd0, segs[s].ld});
        end

        // Clean press with exact edge numbering: pulse only at edge 7, level from edge 7.
        for (int e = 1; e <= 9; e++) begin
            cycle(1'b1, 1'b0);
            chk($sformatf("clean_pulse_e%0d", e), {31'd0, btnc_pulse}, {31'd0, e == 7});
            chk($sformatf("clean_level_e%0d", e), {31'd0, btnc_level}, {31'd0, e >= 7});
        end
        repeat (10) cycle(1'b0, 1'b0);

        // Simultaneous press: both pulses at edge 7 in the same cycle.
        for (int e = 1; e <= 9; e++) begin
            cycle(1'b1, 1'b1);
            if (e == 7) chk("simul_pulses", {30'd0, btnc_pulse, btnd_pulse}, 32'd3);
        end

        // Reset while both are pressed clears the levels at once.
        do_reset();
        // Buttons still held through reset: accepted as a new press.
        for (int e = 1; e <= 9; e++) begin
            cycle(1'b1, 1'b1);
            chk($sformatf("held_c_pulse_e%0d", e), {31'd0, btnc_pulse}, {31'd0, e == 7});
            chk($sformatf("held_d_level_e%0d", e), {31'd0, btnd_level}, {31'd0, e >= 7});
        end
        repeat (10) cycle(1'b0, 1'b0);

        // Reset mid-debounce, four edges into a press, then one full debounce after release.
        repeat (4) cycle(1'b1, 1'b0);
        do_reset();
        pc = 0;
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b1, 1'b0);
            pc += int'(btnc_pulse);
            if (e == 6) chk("midrst_no_early", {31'd0, btnc_level}, 32'd0);
            if (e == 7) chk("midrst_pulse_e7", {31'd0, btnc_pulse}, 32'd1);
        end
        chk("midrst_one_pulse", pc, 1);
        repeat (10) cycle(1'b0, 1'b0);

        // Random stimulus scored only by the reference model.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        // Long random holds to make sure presses actually occur.
        for (int k = 0; k < 20; k++) begin
            logic rc;
            logic rd;
            rc = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) cycle(rc, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
